riscv_lsu: RTL and testbench

- Load/store controller between the decoder/execute stage and the data-memory port.
- Sequences one memory transaction per load/store instruction using the decoder's mem_req/mem_we/mem_size outputs and the ALU address.
- Stalls the core until the transaction completes.
- Builds byte enables and write data, and extracts and extends load data.
- Flags misaligned or illegal-size accesses and memory timeouts.

---
 rtl/riscv_lsu_pkg.sv | 20 ++
 rtl/riscv_lsu_align.sv | 53 +++++
 rtl/riscv_lsu.sv | 143 ++++++++++++++
 tb/tb_riscv_lsu.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared load/store definitions: size codes (common with the decoder), FSM states
// and the default memory timeout.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam int unsigned LSU_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store byte-enable/write-data replication and load
// lane extraction with sign or zero extension.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{ld_off_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  // Loads drive the same enable pattern as a store of that size.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = st_data_i;
    case (st_size_i)
      LDST_B, LDST_BU: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_o    = 4'b0011 << st_off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      LDST_W:  be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  always_comb begin
    ldata_o = 32'h0;
    case (ld_size_i)
      LDST_B:  ldata_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: ldata_o = {24'h0, byte_sel};
      LDST_H:  ldata_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: ldata_o = {16'h0, half_sel};
      LDST_W:  ldata_o = rdata_i;
      default: ldata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store controller: one memory transaction per instruction, stalling the
// core until the grant (stores) or read data (loads) arrives, with a timeout.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [1:0]      off_q;
  logic [2:0]      size_q;
  logic            we_q;

  logic            size_bad, accept, timeout;
  logic [3:0]      be;
  logic [31:0]     wdata, ldata;

  always_comb begin
    size_bad = 1'b0;
    case (lsu_size_i)
      LDST_B, LDST_BU: size_bad = 1'b0;
      LDST_H, LDST_HU: size_bad = lsu_addr_i[0];
      LDST_W:          size_bad = |lsu_addr_i[1:0];
      default:         size_bad = 1'b1;
    endcase
  end

  assign accept  = (state_q == S_IDLE) && lsu_req_i && !size_bad;
  assign timeout = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  riscv_lsu_align u_align (
    .st_size_i (lsu_size_i),
    .st_off_i  (lsu_addr_i[1:0]),
    .st_data_i (lsu_data_i),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .rdata_i   (mem_rdata_i),
    .be_o      (be),
    .wdata_o   (wdata),
    .ldata_o   (ldata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (!mem_gnt_i)    state_d = S_REQ;
          else if (lsu_we_i) state_d = S_DONE;
          else               state_d = S_WAIT;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          data_d  = 32'h0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = ldata;
          state_d = S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          data_d  = 32'h0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Issue registers steer load extraction after the request phase.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      off_q  <= lsu_addr_i[1:0];
      size_q <= lsu_size_i;
      we_q   <= lsu_we_i;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign lsu_misaligned_o = arstn_i && lsu_req_i && size_bad;
  assign mem_req_o        = arstn_i && (accept || state_q == S_REQ);
  assign lsu_stall_req_o  = arstn_i && (accept || state_q == S_REQ || state_q == S_WAIT);
  assign mem_we_o         = arstn_i && lsu_we_i;
  assign mem_be_o         = arstn_i ? be : 4'b0000;
  assign mem_addr_o       = arstn_i ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
  assign mem_wdata_o      = arstn_i ? wdata : 32'h0;
  assign lsu_data_o       = data_q;
  assign lsu_err_o        = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu with directed scenarios and randomized
// transactions against a behavioural load/store model.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_data_i = 32'h0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_misaligned_o, lsu_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data = 32'h0;

  int          n_stall, n_req, n_err, n_mis, done_cyc;
  logic [3:0]  be_s;
  logic [31:0] wd_s, ad_s;
  logic        we_s;

  always #5 clk_i = ~clk_i;

  riscv_lsu #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_misaligned_o(lsu_misaligned_o),
    .lsu_err_o(lsu_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * addr[1:0]);
    case (size)
      LDST_B:  return sh[7]  ? ((sh & 32'hFF)   | 32'hFFFFFF00) : (sh & 32'hFF);
      LDST_BU: return sh & 32'hFF;
      LDST_H:  return sh[15] ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
      LDST_HU: return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      LDST_B, LDST_BU: return 4'(1 << addr[1:0]);
      LDST_H, LDST_HU: return 4'(3 << addr[1:0]);
      default:         return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      LDST_B:  return 32'h01010101 * (d & 32'hFF);
      LDST_H:  return 32'h00010001 * (d & 32'hFFFF);
      default: return d;
    endcase
  endfunction

  // Drives one request and acts as memory; records what the DUT showed each cycle.
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int gnt_dly, input int rv_dly);
    int cyc, gnt_cyc;
    bit fin;
    n_stall = 0; n_req = 0; n_err = 0; n_mis = 0; done_cyc = -1;
    be_s = 4'h0; wd_s = 32'h0; ad_s = 32'h0; we_s = 1'b0;
    cyc = 0; gnt_cyc = -1; fin = 1'b0;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_data_i = wd; mem_rdata_i = rd;
    while (!fin && cyc < 40) begin
      mem_gnt_i    = (gnt_cyc < 0) && (cyc == gnt_dly);
      mem_rvalid_i = !we && (gnt_cyc >= 0) && (cyc == gnt_cyc + rv_dly);
      @(negedge clk_i);
      if (lsu_stall_req_o) n_stall++;
      else begin fin = 1'b1; done_cyc = cyc; end
      if (mem_req_o) begin
        n_req++; be_s = mem_be_o; wd_s = mem_wdata_o; ad_s = mem_addr_o; we_s = mem_we_o;
      end
      if (lsu_err_o) n_err++;
      if (lsu_misaligned_o) n_mis++;
      if (mem_gnt_i && mem_req_o && gnt_cyc < 0) gnt_cyc = cyc;
      @(posedge clk_i); #1;
      cyc++;
    end
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = LDST_W;
    lsu_addr_i = 32'h100; lsu_data_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, lsu_stall_req_o, mem_we_o, lsu_misaligned_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/stall/we/mis=%b required 0000",
               {mem_req_o, lsu_stall_req_o, mem_we_o, lsu_misaligned_o});
    end
    checks++;
    if (mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: be=%h addr=%h wdata=%h required zeros", mem_be_o, mem_addr_o, mem_wdata_o);
    end
    checks++;
    if (lsu_data_o !== 32'h0 || lsu_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: data=%h err=%b required 0/0", lsu_data_o, lsu_err_o);
    end
    lsu_size_i = 3'd3;
    #1;
    checks++;
    if (lsu_misaligned_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mis: got %b required 0", lsu_misaligned_o);
    end
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = LDST_W;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_lw_basic();
    run_txn(1'b0, LDST_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2);
    exp_data = 32'hDEADBEEF;
    checks++;
    if (done_cyc !== 3 || n_stall !== 3) begin
      errors++;
      $display("FAIL lw_stall: done_cycle=%0d stall_cycles=%0d required 3/3", done_cyc, n_stall);
    end
    checks++;
    if (lsu_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_data: got %h required deadbeef", lsu_data_o);
    end
    checks++;
    if (n_req !== 1 || ad_s !== 32'h100 || be_s !== 4'hF || we_s !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus: req_cycles=%0d addr=%h be=%h we=%b required 1/100/f/0", n_req, ad_s, be_s, we_s);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  sz  [3] = '{LDST_B, LDST_BU, LDST_HU};
    logic [31:0] ad  [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exv [3] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, sz[i], ad[i], 32'h0, 32'h80FFFF7F, 1, 1);
      exp_data = exv[i];
      checks++;
      if (lsu_data_o !== exv[i] || done_cyc !== 3) begin
        errors++;
        $display("FAIL load_ext[%0d]: data=%h done=%0d required %h/3", i, lsu_data_o, done_cyc, exv[i]);
      end
    end
  endtask

  task automatic test_store_wait();
    run_txn(1'b1, LDST_B, 32'h201, 32'h12345678, 32'h0, 3, 1);
    checks++;
    if (n_req !== 4 || n_stall !== 4 || done_cyc !== 4) begin
      errors++;
      $display("FAIL sb_timing: req=%0d stall=%0d done=%0d required 4/4/4", n_req, n_stall, done_cyc);
    end
    checks++;
    if (be_s !== 4'b0010 || wd_s !== 32'h78787878 || ad_s !== 32'h200 || we_s !== 1'b1) begin
      errors++;
      $display("FAIL sb_bus: be=%b wdata=%h addr=%h we=%b required 0010/78787878/200/1",
               be_s, wd_s, ad_s, we_s);
    end
    checks++;
    if (lsu_data_o !== exp_data) begin
      errors++;
      $display("FAIL sb_data_hold: got %h required %h", lsu_data_o, exp_data);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  sz [3] = '{LDST_W, LDST_H, 3'd3};
    logic [31:0] ad [3] = '{32'h102, 32'h001, 32'h100};
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      lsu_req_i = 1'b1; lsu_we_i = wr[i]; lsu_size_i = sz[i]; lsu_addr_i = ad[i];
      @(negedge clk_i);
      checks++;
      if ({lsu_misaligned_o, mem_req_o, lsu_stall_req_o} !== 3'b100) begin
        errors++;
        $display("FAIL misaligned[%0d]: mis/req/stall=%b required 100", i,
                 {lsu_misaligned_o, mem_req_o, lsu_stall_req_o});
      end
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({mem_req_o, lsu_stall_req_o} !== 2'b00) begin
        errors++;
        $display("FAIL misaligned_idle[%0d]: req/stall=%b required 00", i, {mem_req_o, lsu_stall_req_o});
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, LDST_W, 32'h400, 32'h0, 32'h55, 0, 1000);
    exp_data = 32'h0;
    checks++;
    if (n_err !== 1 || done_cyc !== TO + 1 || n_stall !== TO + 1) begin
      errors++;
      $display("FAIL timeout_wait: err_pulses=%0d done=%0d stall=%0d required 1/%0d/%0d",
               n_err, done_cyc, n_stall, TO + 1, TO + 1);
    end
    checks++;
    if (lsu_data_o !== 32'h0) begin
      errors++;
      $display("FAIL timeout_data: got %h required 0", lsu_data_o);
    end
    run_txn(1'b1, LDST_W, 32'h404, 32'hA5A5A5A5, 32'h0, 1000, 1);
    checks++;
    if (n_err !== 1 || done_cyc !== TO + 1 || n_req !== TO + 1) begin
      errors++;
      $display("FAIL timeout_req: err_pulses=%0d done=%0d req=%0d required 1/%0d/%0d",
               n_err, done_cyc, n_req, TO + 1, TO + 1);
    end
  endtask

  task automatic test_reset_midflight();
    // Reset while the request is still being offered.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h500; mem_gnt_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL req_hold: mem_req=%b required 1", mem_req_o);
    end
    arstn_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, lsu_stall_req_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_in_req: req/stall=%b required 00", {mem_req_o, lsu_stall_req_o});
    end
    lsu_req_i = 1'b0;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;
    // Reset while waiting for read data; the late rvalid must be ignored.
    lsu_req_i = 1'b1; lsu_addr_i = 32'h600; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, lsu_stall_req_o} !== 2'b01) begin
      errors++;
      $display("FAIL wait_state: req/stall=%b required 01", {mem_req_o, lsu_stall_req_o});
    end
    #1 arstn_i = 1'b0;
    #1;
    exp_data = 32'h0;
    checks++;
    if ({mem_req_o, lsu_stall_req_o} !== 2'b00 || lsu_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait: req/stall=%b data=%h required 00/0",
               {mem_req_o, lsu_stall_req_o}, lsu_data_o);
    end
    lsu_req_i = 1'b0;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (lsu_data_o !== 32'h0 || lsu_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid: data=%h stall=%b required 0/0", lsu_data_o, lsu_stall_req_o);
    end
    @(posedge clk_i); #1;
    run_txn(1'b0, LDST_W, 32'h700, 32'h0, 32'hCAFEF00D, 0, 1);
    exp_data = 32'hCAFEF00D;
    checks++;
    if (done_cyc !== 2 || lsu_data_o !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL post_reset_lw: done=%0d data=%h required 2/cafef00d", done_cyc, lsu_data_o);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, LDST_W, 32'h800, 32'h0, 32'h01020304, 0, 1);
    exp_data = 32'h01020304;
    checks++;
    if (done_cyc !== 2 || lsu_data_o !== 32'h01020304) begin
      errors++;
      $display("FAIL b2b_lw: done=%0d data=%h required 2/01020304", done_cyc, lsu_data_o);
    end
    run_txn(1'b1, LDST_W, 32'h804, 32'h99887766, 32'h0, 0, 1);
    checks++;
    if (done_cyc !== 1 || n_req !== 1 || wd_s !== 32'h99887766 || ad_s !== 32'h804) begin
      errors++;
      $display("FAIL b2b_sw: done=%0d req=%0d wdata=%h addr=%h required 1/1/99887766/804",
               done_cyc, n_req, wd_s, ad_s);
    end
  endtask

  task automatic test_random();
    logic [2:0]  lsz [5] = '{LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] ad, wd, rd;
      int          gd, rv, exp_cyc;
      we = 1'($urandom_range(0, 1));
      sz = we ? lsz[$urandom_range(0, 2)] : lsz[$urandom_range(0, 4)];
      ad = $urandom; wd = $urandom; rd = $urandom;
      if (sz == LDST_W) ad = ad & 32'hFFFFFFFC;
      else if (sz == LDST_H || sz == LDST_HU) ad = ad & 32'hFFFFFFFE;
      gd = $urandom_range(0, 3);
      rv = $urandom_range(1, 3);
      run_txn(we, sz, ad, wd, rd, gd, rv);
      exp_cyc = we ? gd + 1 : gd + rv + 1;
      if (!we) exp_data = ref_load(sz, ad, rd);
      checks++;
      if (done_cyc !== exp_cyc || n_stall !== exp_cyc || n_req !== gd + 1 || n_err !== 0 || n_mis !== 0) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: done=%0d stall=%0d req=%0d err=%0d mis=%0d required %0d/%0d/%0d/0/0",
                 i, done_cyc, n_stall, n_req, n_err, n_mis, exp_cyc, exp_cyc, gd + 1);
      end
      checks++;
      if (be_s !== ref_be(sz, ad) || ad_s !== (ad & 32'hFFFFFFFC) || we_s !== we) begin
        errors++;
        $display("FAIL rnd_bus[%0d]: be=%h addr=%h we=%b required %h/%h/%b",
                 i, be_s, ad_s, we_s, ref_be(sz, ad), ad & 32'hFFFFFFFC, we);
      end
      if (we) begin
        checks++;
        if (wd_s !== ref_wdata(sz, wd)) begin
          errors++;
          $display("FAIL rnd_wdata[%0d]: got %h required %h", i, wd_s, ref_wdata(sz, wd));
        end
      end
      checks++;
      if (lsu_data_o !== exp_data) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got %h required %h", i, lsu_data_o, exp_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw_basic();
    test_load_ext();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
